// File: rtl/crc32_arbiter_if.sv
// rtl/crc32_arbiter_if.sv - requester, result and engine signals of the CRC32 arbiter
interface crc32_arbiter_if;
    logic        req0;
    logic [31:0] data0;
    logic        req1;
    logic [31:0] data1;
    logic        gnt0;
    logic        gnt1;
    logic        res_valid;
    logic        res_id;
    logic [31:0] res_crc;
    logic        res_err;
    logic        res_ack;
    logic [31:0] eng_data;
    logic        eng_load;
    logic        eng_done;
    logic [31:0] eng_crc;

    modport master (
        input  req0, data0, req1, data1, res_ack, eng_done, eng_crc,
        output gnt0, gnt1, res_valid, res_id, res_crc, res_err, eng_data, eng_load
    );

    modport slave (
        output req0, data0, req1, data1, res_ack, eng_done, eng_crc,
        input  gnt0, gnt1, res_valid, res_id, res_crc, res_err, eng_data, eng_load
    );
endinterface

// File: rtl/crc32_arbiter.sv
// rtl/crc32_arbiter.sv - round-robin sharing of one CRC32 engine between two requesters
// Every output is a register; the comb process computes each register's next value.
module crc32_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    crc32_arbiter_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic               r_last_id, w_last_id;
    logic               r_id, w_id;
    logic               r_gnt0, w_gnt0;
    logic               r_gnt1, w_gnt1;
    logic               r_eng_load, w_eng_load;
    logic [31:0]        r_eng_data, w_eng_data;
    logic               r_res_valid, w_res_valid;
    logic               r_res_id, w_res_id;
    logic [31:0]        r_res_crc, w_res_crc;
    logic               r_res_err, w_res_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_id   <= 1'b1;
            r_id        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_eng_load  <= 1'b0;
            r_eng_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_crc   <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_last_id   <= w_last_id;
            r_id        <= w_id;
            r_gnt0      <= w_gnt0;
            r_gnt1      <= w_gnt1;
            r_eng_load  <= w_eng_load;
            r_eng_data  <= w_eng_data;
            r_res_valid <= w_res_valid;
            r_res_id    <= w_res_id;
            r_res_crc   <= w_res_crc;
            r_res_err   <= w_res_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last_id   = r_last_id;
        w_id        = r_id;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_eng_load  = 1'b0;
        w_eng_data  = r_eng_data;
        w_res_valid = r_res_valid;
        w_res_id    = r_res_id;
        w_res_crc   = r_res_crc;
        w_res_err   = r_res_err;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On contention the requester that was not served last wins.
                    w_id       = (bus.req0 && bus.req1) ? ~r_last_id : bus.req1;
                    w_eng_data = w_id ? bus.data1 : bus.data0;
                    w_gnt0     = ~w_id;
                    w_gnt1     = w_id;
                    w_eng_load = 1'b1;
                    w_state    = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt   = '0;
                w_state = S_RUN;
            end
            S_RUN: begin
                if (bus.eng_done) begin
                    w_res_crc   = bus.eng_crc;
                    w_res_err   = 1'b0;
                    w_res_id    = r_id;
                    w_res_valid = 1'b1;
                    w_state     = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_res_crc   = '0;
                    w_res_err   = 1'b1;
                    w_res_id    = r_id;
                    w_res_valid = 1'b1;
                    w_state     = S_RESP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.res_ack) begin
                    w_res_valid = 1'b0;
                    w_res_err   = 1'b0;
                    w_last_id   = r_id;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.eng_load  = r_eng_load;
    assign bus.eng_data  = r_eng_data;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_crc   = r_res_crc;
    assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_crc32_arbiter.sv
// tb/tb_crc32_arbiter.sv - directed self-checking bench for crc32_arbiter
// Engine model: eng_done in the eng_delay-th cycle after the load cycle, crc = word ^ 32'hFFFF_FFFF.
module tb_crc32_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    crc32_arbiter_if bus ();

    crc32_arbiter #(.TIMEOUT(8), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int          eng_delay = 4;
    bit          eng_en    = 1'b1;
    bit          eng_busy  = 1'b0;
    int          eng_cnt   = 0;
    logic [31:0] eng_word  = '0;

    always @(negedge clk) begin
        if (rst) begin
            eng_busy     = 1'b0;
            bus.eng_done = 1'b0;
        end else if (bus.eng_load) begin
            eng_busy     = 1'b1;
            eng_cnt      = 0;
            eng_word     = bus.eng_data;
            bus.eng_done = 1'b0;
        end else if (eng_busy) begin
            eng_cnt++;
            if (eng_en && eng_cnt == eng_delay) begin
                bus.eng_done = 1'b1;
                bus.eng_crc  = eng_word ^ 32'hFFFF_FFFF;
                eng_busy     = 1'b0;
            end else begin
                bus.eng_done = 1'b0;
            end
        end else begin
            bus.eng_done = 1'b0;
        end
    end

    bit bad_overlap = 1'b0;
    bit bad_load    = 1'b0;
    always @(negedge clk) begin
        if (bus.gnt0 && bus.gnt1) bad_overlap = 1'b1;
        if (bus.eng_load !== (bus.gnt0 | bus.gnt1)) bad_load = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_ctl"}, 32'({bus.gnt0, bus.gnt1, bus.eng_load, bus.res_valid, bus.res_id, bus.res_err}), 32'd0);
        chk({tag, "_crc"}, bus.res_crc, 32'd0);
        chk({tag, "_edata"}, bus.eng_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input bit drop, output int id, output int wt);
        bit got;
        got = 1'b0;
        id  = 0;
        wt  = 0;
        while (!got && wt < 100) begin
            @(negedge clk);
            wt++;
            if (bus.gnt0 || bus.gnt1) got = 1'b1;
        end
        chk("grant_seen", 32'(got), 32'd1);
        id = bus.gnt1 ? 1 : 0;
        if (got && drop) begin
            if (id == 0) bus.req0 = 1'b0;
            else         bus.req1 = 1'b0;
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("result_seen", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic do_ack();
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        chk("ack_clears_valid", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic run_txn(input string tag, input bit drop, input int exp_id,
                           input logic [31:0] exp_crc, input bit exp_err, input int exp_lat);
        int id, wt, lat;
        wait_grant(drop, id, wt);
        chk({tag, "_gnt_id"}, 32'(id), 32'(exp_id));
        wait_result(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res_id"}, 32'(bus.res_id), 32'(exp_id));
        chk({tag, "_crc"}, bus.res_crc, exp_crc);
        chk({tag, "_err"}, 32'(bus.res_err), 32'(exp_err));
        do_ack();
    endtask

    initial begin
        int id, wt, lat;
        bit stable, quiet;
        logic [34:0] snap;

        bus.req0 = 1'b0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.data1 = '0;
        bus.res_ack = 1'b0;
        bus.eng_done = 1'b0;
        bus.eng_crc = '0;

        do_reset("reset");

        // Single request: gnt one cycle after req, result five cycles after the load cycle.
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = 32'h1234_5678;
        wait_grant(1'b1, id, wt);
        chk("single_gnt_wait", 32'(wt), 32'd1);
        chk("single_gnt_id", 32'(id), 32'd0);
        wait_result(lat);
        chk("single_lat", 32'(lat), 32'd5);
        chk("single_res_id", 32'(bus.res_id), 32'd0);
        chk("single_crc", bus.res_crc, 32'hEDCB_A987);
        chk("single_err", 32'(bus.res_err), 32'd0);
        do_ack();

        // Contention from reset: requester 0 first, then 1.
        do_reset("reset2");
        bus.req0 = 1'b1; bus.data0 = 32'hA;
        bus.req1 = 1'b1; bus.data1 = 32'hB;
        run_txn("cont1", 1'b1, 0, 32'hFFFF_FFF5, 1'b0, 5);
        run_txn("cont2", 1'b1, 1, 32'hFFFF_FFF4, 1'b0, 5);

        // Fairness with both requests held continuously.
        do_reset("reset3");
        bus.req0 = 1'b1; bus.data0 = 32'h0000_00F0;
        bus.req1 = 1'b1; bus.data1 = 32'h0000_000F;
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("fair%0d", i), 1'b0, i % 2,
                    (i % 2 == 0) ? 32'hFFFF_FF0F : 32'hFFFF_FFF0, 1'b0, 5);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (12) @(negedge clk);

        // Timeout: engine silent, TIMEOUT=8 -> result 9 cycles after the load cycle.
        do_reset("reset4");
        eng_en = 1'b0;
        bus.req0 = 1'b1; bus.data0 = 32'h5;
        run_txn("tmo", 1'b1, 0, 32'h0, 1'b1, 9);
        eng_en = 1'b1;
        bus.req1 = 1'b1; bus.data1 = 32'h0;
        run_txn("after_tmo", 1'b1, 1, 32'hFFFF_FFFF, 1'b0, 5);

        // eng_done on the very cycle the counter expires: done wins.
        eng_delay = 8;
        bus.req0 = 1'b1; bus.data0 = 32'h8000_0001;
        run_txn("edge_done", 1'b1, 0, 32'h7FFF_FFFE, 1'b0, 9);
        // One cycle later is too late: timeout.
        eng_delay = 9;
        bus.req1 = 1'b1; bus.data1 = 32'h3;
        run_txn("edge_late", 1'b1, 1, 32'h0, 1'b1, 9);
        eng_delay = 4;
        repeat (4) @(negedge clk);

        // Backpressure: result held stable while ack stays low.
        bus.req0 = 1'b1; bus.data0 = 32'h0F0F_0F0F;
        wait_grant(1'b1, id, wt);
        wait_result(lat);
        snap = {bus.res_valid, bus.res_id, bus.res_err, bus.res_crc};
        chk("bp_crc", bus.res_crc, 32'hF0F0_F0F0);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_crc} !== snap) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        do_ack();

        // Reset during RUN aborts; requester 0 wins next contention.
        bus.req1 = 1'b1; bus.data1 = 32'h11;
        wait_grant(1'b1, id, wt);
        repeat (2) @(negedge clk);
        do_reset("reset_run");
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.res_valid || bus.gnt0 || bus.gnt1) quiet = 1'b0;
        end
        chk("abort_quiet", 32'(quiet), 32'd1);
        bus.req0 = 1'b1; bus.data0 = 32'h22;
        bus.req1 = 1'b1; bus.data1 = 32'h33;
        run_txn("post_rst", 1'b1, 0, 32'hFFFF_FFDD, 1'b0, 5);
        run_txn("post_rst2", 1'b1, 1, 32'hFFFF_FFCC, 1'b0, 5);

        chk("gnt_no_overlap", 32'(bad_overlap), 32'd0);
        chk("load_only_in_load", 32'(bad_load), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
